// File: rtl/sap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap_pkg : shared opcodes, phase encoding and widths for SAP-1        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sap_pkg;

    localparam int ADDR_W = 4;
    localparam int WORD_W = 8;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        T6   = 3'd5,
        HALT = 3'd6
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/sap_ring_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap_ring_counter : T1..T6 phase register with run enable and HALT    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   run,
    input  logic   halt_req,
    output phase_e phase
);

    phase_e phase_q;
    phase_e phase_d;

    always_comb begin
        phase_d = phase_q;
        // HALT is terminal; run is ignored there
        if (phase_q != HALT && run) begin
            case (phase_q)
                T1:      phase_d = T2;
                T2:      phase_d = T3;
                T3:      phase_d = T4;
                T4:      phase_d = halt_req ? HALT : T5;
                T5:      phase_d = T6;
                T6:      phase_d = T1;
                default: phase_d = T1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= T1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/sap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sap_sequencer : SAP-1 fetch/execute sequencer and accumulator path.  |
// | Optional SAP_FLAGS_EN adds carry/zero outputs.  Rev 1.0              |
// +----------------------------------------------------------------------+
module sap_sequencer
    import sap_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
`ifdef SAP_FLAGS_EN
    output logic              carry,
    output logic              zero,
`endif
    output logic [ADDR_W-1:0] pc
);

    phase_e phase;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
`ifdef SAP_FLAGS_EN
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
`endif

    logic [3:0] opcode;
    assign opcode = ir_q[7:4];

    sap_ring_counter u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .halt_req (opcode == OP_HLT),
        .phase    (phase)
    );

    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        b_d         = b_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
`ifdef SAP_FLAGS_EN
        carry_d     = carry_q;
        zero_d      = zero_q;
`endif
        if (run && phase != HALT) begin
            case (phase)
                T1: mar_d = pc_q;
                T2: pc_d  = pc_q + 4'd1;
                T3: ir_d  = rom_data;
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        mar_d = ir_q[3:0];
                    end else if (opcode == OP_OUT) begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        acc_d = rom_data;
`ifdef SAP_FLAGS_EN
                        zero_d = (rom_data == '0);
`endif
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        b_d = rom_data;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD) begin
`ifdef SAP_FLAGS_EN
                        {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, b_q};
                        zero_d = (acc_d == '0);
`else
                        acc_d = acc_q + b_q;
`endif
                    end else if (opcode == OP_SUB) begin
                        acc_d = acc_q - b_q;
`ifdef SAP_FLAGS_EN
                        // borrow-not: set when no borrow is needed
                        carry_d = (acc_q >= b_q);
                        zero_d  = (acc_d == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef SAP_FLAGS_EN
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef SAP_FLAGS_EN
            carry_q     <= carry_d;
            zero_q      <= zero_d;
`endif
        end
    end

    assign rom_addr  = mar_q;
    assign pc        = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (phase == HALT);
`ifdef SAP_FLAGS_EN
    assign carry     = carry_q;
    assign zero      = zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sap_sequencer : directed self-checking bench for sap_sequencer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sap_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b1;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic [3:0] pc;
`ifdef SAP_FLAGS_EN
    logic       carry;
    logic       zero;
`endif

    logic [7:0] rom [16];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    sap_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
`ifdef SAP_FLAGS_EN
        .carry     (carry),
        .zero      (zero),
`endif
        .pc        (pc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    task automatic load_std();
        fill_rom(8'h00);
        rom[0] = 8'h09; rom[1] = 8'h1A; rom[2] = 8'h1B; rom[3] = 8'h2C;
        rom[4] = 8'hE0; rom[5] = 8'hF0;
        rom[9] = 8'h10; rom[10] = 8'h14; rom[11] = 8'h18; rom[12] = 8'h20;
    endtask

    // Cycle 1 is the cycle in which rst_n is released (phase T1).
    task automatic start();
        rst_n = 1'b0;
        run   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc = 1;
    endtask

    initial begin
        // Standard program: 0x10 + 0x14 + 0x18 - 0x20 = 0x1C
        load_std();
        start();
        chk("reset_pc", pc, 4'h0);
        chk("reset_rom_addr", rom_addr, 4'h0);
        chk("reset_out_data", out_data, 8'h00);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_halted", halted, 1'b0);
`ifdef SAP_FLAGS_EN
        chk("reset_carry", carry, 1'b0);
        chk("reset_zero", zero, 1'b0);
`endif
        run_to(3);  chk("std_pc_c3", pc, 4'h1);
        run_to(28); chk("std_ov_c28", out_valid, 1'b0);
        run_to(29); chk("std_ov_c29", out_valid, 1'b1);
                    chk("std_out_c29", out_data, 8'h1C);
        run_to(30); chk("std_ov_c30", out_valid, 1'b0);
        run_to(34); chk("std_halt_c34", halted, 1'b0);
        run_to(35); chk("std_halt_c35", halted, 1'b1);
        run_to(45); chk("std_pc_end", pc, 4'h6);
                    chk("std_halt_end", halted, 1'b1);
                    chk("std_out_hold", out_data, 8'h1C);
                    chk("std_ov_end", out_valid, 1'b0);

        // ADD overflow: 0xF0 + 0x20 = 0x110
        fill_rom(8'h00);
        rom[0] = 8'h08; rom[1] = 8'h19; rom[2] = 8'hE0; rom[3] = 8'hF0;
        rom[8] = 8'hF0; rom[9] = 8'h20;
        start();
        run_to(17); chk("add_ov_pulse", out_valid, 1'b1);
                    chk("add_ov_acc", out_data, 8'h10);
`ifdef SAP_FLAGS_EN
                    chk("add_ov_carry", carry, 1'b1);
                    chk("add_ov_zero", zero, 1'b0);
`endif

        // SUB to zero: 0x20 - 0x20
        fill_rom(8'h00);
        rom[0] = 8'h08; rom[1] = 8'h29; rom[2] = 8'hE0; rom[3] = 8'hF0;
        rom[8] = 8'h20; rom[9] = 8'h20;
        start();
        run_to(17); chk("sub_z_pulse", out_valid, 1'b1);
                    chk("sub_z_acc", out_data, 8'h00);
`ifdef SAP_FLAGS_EN
                    chk("sub_z_carry", carry, 1'b1);
                    chk("sub_z_zero", zero, 1'b1);
`endif

        // All-NOP ROM for 100 cycles, then switch ROM to OUT to expose ACC
        begin
            int bad_ov;
            int bad_halt;
            bad_ov = 0;
            bad_halt = 0;
            fill_rom(8'h30);
            start();
            while (cyc < 100) begin
                tick();
                if (out_valid !== 1'b0) bad_ov++;
                if (halted !== 1'b0) bad_halt++;
                if (cyc == 92) chk("nop_pc_c92", pc, 4'hF);
                if (cyc == 93) chk("nop_pc_wrap", pc, 4'h0);
            end
            chk("nop_no_pulse", bad_ov, 0);
            chk("nop_no_halt", bad_halt, 0);
            fill_rom(8'hE0);
            run_to(106); chk("nop_ov_c106", out_valid, 1'b0);
            run_to(107); chk("nop_acc_pulse", out_valid, 1'b1);
                         chk("nop_acc_zero", out_data, 8'h00);
        end

        // run low for 5 cycles starting in OUT's T4 (cycle 28)
        load_std();
        start();
        run_to(28);
        run = 1'b0;
        for (int c = 29; c <= 33; c++) begin
            run_to(c);
            chk("stall_ov", out_valid, 1'b0);
            chk("stall_pc", pc, 4'h5);
            chk("stall_mar", rom_addr, 4'h4);
        end
        run = 1'b1;
        run_to(34); chk("stall_pulse", out_valid, 1'b1);
                    chk("stall_out", out_data, 8'h1C);
        run_to(35); chk("stall_once", out_valid, 1'b0);
        run_to(39); chk("stall_halt_c39", halted, 1'b0);
        run_to(40); chk("stall_halt_c40", halted, 1'b1);

        // Reset mid-T5 of ADD, then re-execution from address 0
        fill_rom(8'h00);
        rom[0] = 8'h09; rom[1] = 8'hE0; rom[2] = 8'h1A; rom[3] = 8'hE0;
        rom[4] = 8'hF0; rom[9] = 8'h10; rom[10] = 8'h14;
        start();
        run_to(11); chk("rst_first_pulse", out_valid, 1'b1);
                    chk("rst_first_out", out_data, 8'h10);
        run_to(17);
        rst_n = 1'b0;
        #1;
        chk("rst_async_pc", pc, 4'h0);
        chk("rst_async_addr", rom_addr, 4'h0);
        chk("rst_async_out", out_data, 8'h00);
        chk("rst_async_halt", halted, 1'b0);
        start();
        run_to(10); chk("rerun_ov_c10", out_valid, 1'b0);
        run_to(11); chk("rerun_pulse1", out_valid, 1'b1);
                    chk("rerun_out1", out_data, 8'h10);
        run_to(23); chk("rerun_pulse2", out_valid, 1'b1);
                    chk("rerun_out2", out_data, 8'h24);
        run_to(28); chk("rerun_halt_c28", halted, 1'b0);
        run_to(29); chk("rerun_halt_c29", halted, 1'b1);
                    chk("rerun_pc", pc, 4'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
